// File: rtl/ctrl_time_seq.sv
// Programmable time-scheduled step sequencer: walks a runtime-loaded table of
// (switch time, value) segments against an external step counter.
module ctrl_time_seq #(
  parameter int N_SEG = 8,
  parameter int W_CNT = 12,
  parameter int W_VAL = 64,
  localparam int AW = $clog2(N_SEG + 1)
) (
  input  logic             clk,
  input  logic             sta,
  input  logic [W_CNT-1:0] counter,
  input  logic             mode,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [W_CNT-1:0] cfg_time,
  input  logic [W_VAL-1:0] cfg_value,
  input  logic             cfg_len_we,
  input  logic [AW-1:0]    cfg_len,
  output logic [W_VAL-1:0] y,
  output logic [AW-1:0]    seg_idx,
  output logic             seg_strobe,
  output logic             done
);

  // Power-of-two depth keeps every AW-bit index in range; entries above N_SEG stay unused.
  localparam int DEPTH = 1 << AW;

  logic [W_CNT-1:0] time_reg  [DEPTH];
  logic [W_VAL-1:0] value_reg [DEPTH];
  logic [AW-1:0]    n_act_reg;

  logic [AW-1:0]    seg_idx_reg, seg_idx_next;
  logic [W_VAL-1:0] y_reg, y_next;
  logic             strobe_reg, strobe_next;
  logic             done_reg, done_next;

  logic [AW-1:0]    nxt_idx;
  logic [W_CNT-1:0] nxt_time_m1;
  logic [W_CNT-1:0] first_time_m1;
  logic             adv;
  logic             rearm;

  // Table is deliberately outside the sequencer reset so a restart replays it.
  always_ff @(posedge clk) begin
    if (cfg_we && (cfg_addr <= AW'(N_SEG))) begin
      value_reg[cfg_addr] <= cfg_value;
      if (cfg_addr != '0) begin
        time_reg[cfg_addr] <= cfg_time;
      end
    end
    if (cfg_len_we) begin
      n_act_reg <= (cfg_len > AW'(N_SEG)) ? AW'(N_SEG) : cfg_len;
    end
  end

  always_comb begin
    // seg_idx < n_act <= N_SEG whenever nxt_idx is used, so it never wraps.
    nxt_idx       = seg_idx_reg + AW'(1);
    nxt_time_m1   = time_reg[nxt_idx] - W_CNT'(1);
    first_time_m1 = time_reg[1] - W_CNT'(1);
    adv   = (seg_idx_reg < n_act_reg) && (counter == nxt_time_m1);
    rearm = mode && (n_act_reg != '0) && (seg_idx_reg >= n_act_reg) &&
            (counter == first_time_m1);

    seg_idx_next = seg_idx_reg;
    y_next       = value_reg[seg_idx_reg];
    strobe_next  = 1'b0;
    if (adv) begin
      seg_idx_next = nxt_idx;
      y_next       = value_reg[nxt_idx];
      strobe_next  = 1'b1;
    end else if (rearm) begin
      // Cyclic re-arm restarts at segment 1; entry 0 is only the post-restart value.
      seg_idx_next = AW'(1);
      y_next       = value_reg[1];
      strobe_next  = 1'b1;
    end
    done_next = (seg_idx_next == n_act_reg);
  end

  always_ff @(posedge clk) begin
    if (sta) begin
      seg_idx_reg <= '0;
      y_reg       <= '0;
      strobe_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      seg_idx_reg <= seg_idx_next;
      y_reg       <= y_next;
      strobe_reg  <= strobe_next;
      done_reg    <= done_next;
    end
  end

  assign y          = y_reg;
  assign seg_idx    = seg_idx_reg;
  assign seg_strobe = strobe_reg;
  assign done       = done_reg;

endmodule
